lsu: RTL and testbench
======================

# lsu

Multicycle load/store unit directly downstream of the ALU. It takes the effective address the ALU produces (`num1 + num2` under the add op) plus store data and funct3, and runs one memory transaction against a variable-latency memory port. For stores it builds the byte mask and steers the data onto the correct lanes. For loads it extracts the addressed bytes and sign- or zero-extends them. It returns a 32-bit result and an error flag to the execute/write-back control FSM.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Only 32 is supported.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `req_valid` in 1: a memory op is offered.
- `req_ready` out 1: LSU can accept a request; high only in IDLE.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in ADDR_W: effective address, taken from the ALU result.
- `req_wdata` in DATA_W: store data (rs2), right-aligned.
- `mem_valid` out 1: memory request valid.
- `mem_ready` in 1: memory accepts the request.
- `mem_wen` out 1: store request.
- `mem_addr` out ADDR_W: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_wdata` out DATA_W: lane-steered store data.
- `mem_wmask` out 4: byte-enable mask; `4'b0000` for loads.
- `mem_rvalid` in 1: read data or write acknowledge.
- `mem_rdata` in DATA_W: read word.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer takes the result.
- `resp_data` out DATA_W: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access or illegal funct3.

## Operation
- States: IDLE, REQ, WAIT, RESP (encoded in 2 bits).
- IDLE, when `req_valid` is high: latch wen, funct3, addr and wdata. Go to REQ if the request is legal. Otherwise set `err` and go to RESP with no memory access.
- Illegal requests:
  - Halfword op with `addr[0]=1`.
  - Word op with `addr[1:0]!=0`.
  - Load funct3 of 3, 6 or 7.
  - Store funct3 greater than 2.
- REQ: `mem_valid`=1. The request signals stay stable until `mem_ready`, then go to WAIT. `mem_rvalid` is ignored in REQ.
- WAIT: on `mem_rvalid`, capture the extended load result (0 for stores) and go to RESP.
- RESP: `resp_valid`=1 and `resp_data`/`resp_err` stay stable until `resp_ready`, then go to IDLE.
- Store steering, where `o = addr[1:0]`:
  - SB: mask `4'b0001<<o`, data `{4{wdata[7:0]}}`.
  - SH: mask `4'b0011<<o`, data `{2{wdata[15:0]}}`.
  - SW: mask `4'b1111`, data `wdata`.
- Load extraction: `sh = mem_rdata >> (8*o)`, then:
  - LB: sign-extend `sh[7:0]`.
  - LBU: zero-extend `sh[7:0]`.
  - LH: sign-extend `sh[15:0]`.
  - LHU: zero-extend `sh[15:0]`.
  - LW: `sh`.
- `rst` forces IDLE from any state, including mid-REQ or mid-WAIT. The in-flight transaction is dropped and any later `mem_rvalid` is ignored.

## Timing
- Reset values: `req_ready`=1 (IDLE). `mem_valid`, `mem_wen`, `resp_valid` and `resp_err` = 0. `mem_addr`, `mem_wdata`, `mem_wmask` and `resp_data` = 0.
- Minimum legal latency is 3 cycles from the accept edge to `resp_valid`: accept at cycle 0, REQ with `mem_ready` at cycle 1, WAIT with `mem_rvalid` at cycle 2, RESP at cycle 3.
- An illegal request gives `resp_valid` at cycle 1.
- No back-to-back overlap: `req_ready` returns the cycle after the RESP handshake.
- Outputs are registered or decoded purely from state and latched fields. There is no combinational path from `mem_rdata` to `resp_data`.
- Stall tolerance: any number of cycles with `mem_ready`=0, `mem_rvalid`=0 or `resp_ready`=0 holds state and all outputs unchanged.

## Structure
- Package `lsu_pkg` holds:
  - The state enum `lsu_state_t`.
  - The funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - A `misaligned(funct3, addr)` function.
- Combinational sub-module `lsu_align`: store mask/data steering and load extract/extend, shared by the store and load paths.
- The top level holds only the FSM and the latches.

## Test plan
- LW at `0x8000_0004`, `mem_rdata`=`0xDEADBEEF`, 0-cycle memory -> `resp_data`=`0xDEADBEEF`, `resp_err`=0, `resp_valid` at cycle 3.
- LB at `0x8000_0003`, `mem_rdata`=`0x80112233` -> `resp_data`=`0xFFFFFF80`. LBU at the same address -> `0x00000080`.
- SB at `0x8000_0002`, `wdata`=`0x000000AB` -> `mem_wmask`=`4'b0100`, `mem_wdata`=`0xABABABAB`, `mem_addr`=`0x8000_0000`, `resp_data`=0.
- LH at `0x8000_0001` -> no `mem_valid` ever, `resp_valid` at cycle 1 with `resp_err`=1.
- SW with `mem_ready` low 5 cycles, `mem_rvalid` low 7 cycles and `resp_ready` low 2 cycles -> all outputs stable throughout; the response is delivered exactly once.
- `rst` pulsed during WAIT, then a stray `mem_rvalid` -> LSU in IDLE, `req_ready`=1, `resp_valid` stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request legality helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Only the two low address bits matter for natural alignment.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_H, F3_HU: misaligned = addr[0];
            F3_W:        misaligned = (addr != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic illegal_funct3(input logic wen, input logic [2:0] funct3);
        if (wen) begin
            illegal_funct3 = (funct3 > F3_W);
        end else begin
            illegal_funct3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and byte/halfword extraction with extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'd0: begin
                wmask_o = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                wmask_o = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            2'd2: begin
                wmask_o = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                wmask_o = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        load_o = shifted;
        case (funct3_i)
            F3_B:    load_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_o = {24'h0, shifted[7:0]};
            F3_H:    load_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_o = {16'h0, shifted[15:0]};
            default: load_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Multicycle load/store unit: one memory transaction per request, result held until taken.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err
);

    lsu_state_t        state_q, state_d;
    logic              wen_q, wen_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic [3:0]        st_mask;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] ld_data;

    lsu_align u_align (
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata),
        .wmask_o  (st_mask),
        .wdata_o  (st_data),
        .load_o   (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        resp_data_d = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d    = req_wen;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    // Illegal requests skip memory and report straight away.
                    if (illegal_funct3(req_wen, req_funct3) ||
                        misaligned(req_funct3, req_addr[1:0])) begin
                        err_d       = 1'b1;
                        resp_data_d = '0;
                        state_d     = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    resp_data_d = wen_q ? '0 : ld_data;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wen_q       <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Outputs decode from state and latched fields only, so they are quiet outside their phase.
    assign req_ready  = (state_q == S_IDLE);
    assign mem_valid  = (state_q == S_REQ);
    assign mem_wen    = mem_valid & wen_q;
    assign mem_addr   = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata  = mem_wen ? st_data : '0;
    assign mem_wmask  = mem_wen ? st_mask : 4'b0000;
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_valid ? resp_data_q : '0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single transactions plus stall and reset sequences.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    typedef struct {
        string       name;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic err, input logic [3:0] mask, input logic [31:0] mwdata,
                       input logic [31:0] data);
        vec_t v;
        v.name = name; v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.mask = mask; v.mwdata = mwdata; v.data = data;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    // One transaction with a zero-wait memory; checks latency, memory request and response.
    task automatic run_vec(input vec_t v);
        int          cyc;
        logic        seen_mem;
        logic        m_wen;
        logic [31:0] m_addr, m_wdata;
        logic [3:0]  m_mask;
        @(negedge clk);
        check({v.name, " req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_wen = v.wen; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        mem_rdata = v.rdata; mem_ready = 1'b1; mem_rvalid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1 idle_inputs();
        cyc = 1; seen_mem = 1'b0;
        m_wen = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_mask = 4'h0;
        while (cyc < 20) begin
            @(negedge clk);
            if (mem_valid && !seen_mem) begin
                seen_mem = 1'b1;
                m_wen = mem_wen; m_addr = mem_addr; m_wdata = mem_wdata; m_mask = mem_wmask;
            end
            if (resp_valid) break;
            @(posedge clk);
            cyc++;
        end
        check({v.name, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
        check({v.name, " latency"}, cyc, v.err ? 32'd1 : 32'd3);
        check({v.name, " resp_err"}, {31'h0, resp_err}, {31'h0, v.err});
        check({v.name, " resp_data"}, resp_data, v.data);
        check({v.name, " mem_valid seen"}, {31'h0, seen_mem}, {31'h0, !v.err});
        if (!v.err) begin
            check({v.name, " mem_wen"}, {31'h0, m_wen}, {31'h0, v.wen});
            check({v.name, " mem_addr"}, m_addr, v.addr & 32'hFFFF_FFFC);
            check({v.name, " mem_wmask"}, {28'h0, m_mask}, {28'h0, v.mask});
            check({v.name, " mem_wdata"}, m_wdata, v.mwdata);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        check({v.name, " back to idle"}, {30'h0, req_ready, resp_valid}, 32'h2);
    endtask

    initial begin
        logic        ok;
        int          resp_cycles;
        logic [31:0] snap_addr, snap_wdata;
        logic [3:0]  snap_mask;

        rst = 1'b1;
        idle_inputs();
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; resp_ready = 1'b0;

        //   name         wen f3     addr          wdata         rdata         err mask     mwdata        data
        add("LW",         0, 3'd2, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 0, 4'b0000, 32'h0,        32'hDEAD_BEEF);
        add("LB",         0, 3'd0, 32'h8000_0003, 32'h0,        32'h8011_2233, 0, 4'b0000, 32'h0,        32'hFFFF_FF80);
        add("LBU",        0, 3'd4, 32'h8000_0003, 32'h0,        32'h8011_2233, 0, 4'b0000, 32'h0,        32'h0000_0080);
        add("LB off1",    0, 3'd0, 32'h8000_0001, 32'h0,        32'h8011_2233, 0, 4'b0000, 32'h0,        32'h0000_0022);
        add("LH off2",    0, 3'd1, 32'h8000_0002, 32'h0,        32'h8011_2233, 0, 4'b0000, 32'h0,        32'hFFFF_8011);
        add("LHU off2",   0, 3'd5, 32'h8000_0002, 32'h0,        32'h8011_2233, 0, 4'b0000, 32'h0,        32'h0000_8011);
        add("SB",         1, 3'd0, 32'h8000_0002, 32'h0000_00AB, 32'h5555_5555, 0, 4'b0100, 32'hABAB_ABAB, 32'h0);
        add("SH",         1, 3'd1, 32'h8000_0002, 32'h1234_CDEF, 32'h5555_5555, 0, 4'b1100, 32'hCDEF_CDEF, 32'h0);
        add("SW",         1, 3'd2, 32'h8000_0008, 32'h1234_5678, 32'h5555_5555, 0, 4'b1111, 32'h1234_5678, 32'h0);
        add("LH misalig", 0, 3'd1, 32'h8000_0001, 32'h0,        32'hDEAD_BEEF, 1, 4'b0000, 32'h0,        32'h0);
        add("LW misalig", 0, 3'd2, 32'h8000_0002, 32'h0,        32'hDEAD_BEEF, 1, 4'b0000, 32'h0,        32'h0);
        add("LD f3=3",    0, 3'd3, 32'h8000_0000, 32'h0,        32'hDEAD_BEEF, 1, 4'b0000, 32'h0,        32'h0);
        add("ST f3=4",    1, 3'd4, 32'h8000_0000, 32'h0000_00AB, 32'hDEAD_BEEF, 1, 4'b0000, 32'h0,       32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset ctl", {29'h0, mem_valid, mem_wen, resp_valid}, 32'h0);
        check("reset resp_err", {31'h0, resp_err}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset mem_wmask", {28'h0, mem_wmask}, 32'h0);
        check("reset resp_data", resp_data, 32'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // SW with stalls on every handshake; stray mem_rvalid during REQ must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h8000_0010; req_wdata = 32'hCAFE_F00D;
        mem_ready = 1'b0; mem_rvalid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1 idle_inputs();
        ok = 1'b1;
        snap_addr = 32'h8000_0010; snap_wdata = 32'hCAFE_F00D; snap_mask = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(mem_valid && mem_wen && mem_addr == snap_addr && mem_wdata == snap_wdata &&
                  mem_wmask == snap_mask && !resp_valid && !req_ready)) ok = 1'b0;
            @(posedge clk);
        end
        check("stall REQ stable", {31'h0, ok}, 32'h1);
        @(negedge clk);
        mem_ready = 1'b1; mem_rvalid = 1'b0;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (mem_valid || resp_valid || req_ready) ok = 1'b0;
            @(posedge clk);
        end
        check("stall WAIT stable", {31'h0, ok}, 32'h1);
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        ok = 1'b1; resp_cycles = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (resp_valid) resp_cycles++;
            if (!(resp_valid && !resp_err && resp_data == 32'h0 && !mem_valid)) ok = 1'b0;
            @(posedge clk);
        end
        check("stall RESP stable", {31'h0, ok}, 32'h1);
        @(negedge clk);
        if (resp_valid) resp_cycles++;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) resp_cycles++;
        end
        check("stall resp once", resp_cycles, 32'd3);
        check("stall idle after", {31'h0, req_ready}, 32'h1);

        // Reset while waiting for read data; a late mem_rvalid must not produce a response.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'h8000_0020; mem_ready = 1'b1; mem_rvalid = 1'b0;
        mem_rdata = 32'h1111_2222;
        @(posedge clk);
        #1 idle_inputs();
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check("rst-wait in WAIT", {29'h0, mem_valid, resp_valid, req_ready}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mem_rvalid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!req_ready || resp_valid || mem_valid || resp_data != 32'h0) ok = 1'b0;
        end
        mem_rvalid = 1'b0;
        check("rst-wait idle, no resp", {31'h0, ok}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
